// File: rtl/q2_cycle_pkg.sv
// Shared machine-state encoding, phase constants and boundary helper for the q2 cycle sequencer.
package q2_cycle_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        HALT  = 3'd0,
        FETCH = 3'd1,
        DEFER = 3'd2,
        EXEC  = 3'd3,
        STORE = 3'd4
    } state_t;

    localparam logic PH_ADDR = 1'b0;
    localparam logic PH_DATA = 1'b1;

    // Next state at an instruction boundary: a single-stepped instruction always stops.
    function automatic state_t boundary_next(input logic halt_req,
                                             input logic run,
                                             input logic step_mode);
        return (halt_req || !run || step_mode) ? HALT : FETCH;
    endfunction

endpackage

// File: rtl/q2_cycle_seq_if.sv
// Control/status bundle between the CPU datapath and the q2 cycle sequencer.
interface q2_cycle_seq_if;
    import q2_cycle_pkg::*;

    logic               run;
    logic               step;
    logic               mem_ready;
    logic               indirect;
    logic               needs_store;
    logic               halt_insn;
    logic               cdiv;
    logic               ncdiv;
    logic [STATE_W-1:0] state;
    logic               ir_load;
    logic               pc_inc;
    logic               running;
    logic               fault;

    modport master (
        output run, step, mem_ready, indirect, needs_store, halt_insn,
        input  cdiv, ncdiv, state, ir_load, pc_inc, running, fault
    );

    modport slave (
        input  run, step, mem_ready, indirect, needs_store, halt_insn,
        output cdiv, ncdiv, state, ir_load, pc_inc, running, fault
    );

endinterface

// File: rtl/q2_wait_timer.sv
// Counts consecutive phase-1 wait clocks; o_timeout flags the clock on which the count would reach MAX_WAIT.
module q2_wait_timer #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 7
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = i_inc && (r_count == LIMIT);

endmodule

// File: rtl/q2_cycle_seq.sv
// Machine-cycle sequencer: FETCH/DEFER/EXEC/STORE, two clk phases per state, wait states and timeout.
// Optional single-step from HALT is enabled by defining Q2_CYCLE_SEQ_STEP_EN.
module q2_cycle_seq
    import q2_cycle_pkg::*;
#(
    parameter int MAX_WAIT = 7,
    parameter int WAIT_W   = 4
) (
    input  logic           clk,
    input  logic           nreset,
    q2_cycle_seq_if.slave  bus
);

    state_t r_state;
    logic   r_cdiv;
    logic   r_fault;
    logic   r_halt_pend;
    logic   r_step_mode;

    state_t w_next_state;
    logic   w_next_cdiv;
    logic   w_next_fault;
    logic   w_next_halt_pend;
    logic   w_next_step_mode;
    logic   w_active;
    logic   w_wait;
    logic   w_timeout;

    assign w_active = (r_state == FETCH) || (r_state == DEFER) ||
                      (r_state == EXEC)  || (r_state == STORE);
    assign w_wait   = w_active && (r_cdiv == PH_DATA) && !bus.mem_ready;

    q2_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .nreset    (nreset),
        .i_clear   (!w_wait || w_timeout),
        .i_inc     (w_wait),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= HALT;
            r_cdiv      <= PH_ADDR;
            r_fault     <= 1'b0;
            r_halt_pend <= 1'b0;
            r_step_mode <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cdiv      <= w_next_cdiv;
            r_fault     <= w_next_fault;
            r_halt_pend <= w_next_halt_pend;
            r_step_mode <= w_next_step_mode;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_cdiv      = r_cdiv;
        w_next_fault     = r_fault;
        w_next_halt_pend = r_halt_pend;
        w_next_step_mode = r_step_mode;

        case (r_state)
            HALT: begin
                w_next_cdiv      = PH_ADDR;
                w_next_step_mode = 1'b0;
                if (!r_fault) begin
                    if (bus.run) begin
                        w_next_state = FETCH;
                    end
`ifdef Q2_CYCLE_SEQ_STEP_EN
                    else if (bus.step) begin
                        w_next_state     = FETCH;
                        w_next_step_mode = 1'b1;
                    end
`endif
                end
            end

            FETCH, DEFER, EXEC, STORE: begin
                if (r_cdiv == PH_ADDR) begin
                    w_next_cdiv = PH_DATA;
                end else if (bus.mem_ready) begin
                    w_next_cdiv = PH_ADDR;
                    case (r_state)
                        FETCH: w_next_state = bus.indirect ? DEFER : EXEC;
                        DEFER: w_next_state = EXEC;
                        EXEC: begin
                            w_next_halt_pend = bus.halt_insn;
                            if (bus.needs_store) begin
                                w_next_state = STORE;
                            end else begin
                                w_next_state = boundary_next(bus.halt_insn, bus.run, r_step_mode);
                            end
                        end
                        default: w_next_state = boundary_next(r_halt_pend, bus.run, r_step_mode);
                    endcase
                end else if (w_timeout) begin
                    w_next_fault = 1'b1;
                    w_next_state = HALT;
                    w_next_cdiv  = PH_ADDR;
                end
            end

            // Encodings 5-7 can only come from an upset; park safely and flag it.
            default: begin
                w_next_state = HALT;
                w_next_cdiv  = PH_ADDR;
                w_next_fault = 1'b1;
            end
        endcase
    end

    assign bus.cdiv    = r_cdiv;
    assign bus.ncdiv   = ~r_cdiv;
    assign bus.state   = r_state;
    assign bus.running = (r_state != HALT);
    assign bus.fault   = r_fault;
    assign bus.ir_load = nreset && (r_state == FETCH) && (r_cdiv == PH_DATA) && bus.mem_ready;
    assign bus.pc_inc  = bus.ir_load;

endmodule

// File: tb/tb_q2_cycle_seq.sv
// Scoreboard bench for q2_cycle_seq: directed per-cycle vectors push expectations, a negedge monitor checks them.
module tb_q2_cycle_seq;
    import q2_cycle_pkg::*;

    logic clk    = 1'b0;
    logic nreset = 1'b0;

    q2_cycle_seq_if bus ();

    q2_cycle_seq #(
        .MAX_WAIT (7),
        .WAIT_W   (4)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        state_t st;
        logic   cdiv;
        logic   ir;
        logic   flt;
        string  nm;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic compareField(input string nm, input string fld,
                                input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s/%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField(e.nm, "state",   bus.state,          e.st);
        compareField(e.nm, "cdiv",    {2'b0, bus.cdiv},    {2'b0, e.cdiv});
        compareField(e.nm, "ncdiv",   {2'b0, bus.ncdiv},   {2'b0, ~e.cdiv});
        compareField(e.nm, "ir_load", {2'b0, bus.ir_load}, {2'b0, e.ir});
        compareField(e.nm, "pc_inc",  {2'b0, bus.pc_inc},  {2'b0, e.ir});
        compareField(e.nm, "running", {2'b0, bus.running}, {2'b0, (e.st != HALT)});
        compareField(e.nm, "fault",   {2'b0, bus.fault},   {2'b0, e.flt});
    endtask

    // Drive inputs for the coming cycle and queue what the DUT must show during it.
    task automatic applyStimulus(input logic nr, input logic rn, input logic stp,
                                 input logic mr, input logic ind, input logic ns,
                                 input logic hlt, input state_t es, input logic ec,
                                 input logic eir, input logic ef, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        nreset          = nr;
        bus.run         = rn;
        bus.step        = stp;
        bus.mem_ready   = mr;
        bus.indirect    = ind;
        bus.needs_store = ns;
        bus.halt_insn   = hlt;
        e.st   = es;
        e.cdiv = ec;
        e.ir   = eir;
        e.flt  = ef;
        e.nm   = nm;
        expQ.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        bus.run = 1'b0; bus.step = 1'b0; bus.mem_ready = 1'b0;
        bus.indirect = 1'b0; bus.needs_store = 1'b0; bus.halt_insn = 1'b0;

        applyStimulus(0,0,0,0,0,0,0, HALT, 0,0,0, "resetA");
        applyStimulus(0,0,0,0,0,0,0, HALT, 0,0,0, "resetB");
        applyStimulus(1,1,0,1,0,0,0, HALT, 0,0,0, "haltIdle");
        applyStimulus(1,1,0,1,0,0,0, FETCH,0,0,0, "fetchAddr1");
        applyStimulus(1,1,0,1,0,0,0, FETCH,1,1,0, "fetchData1");
        applyStimulus(1,1,0,1,0,0,0, EXEC, 0,0,0, "execAddr1");
        applyStimulus(1,1,0,1,0,0,0, EXEC, 1,0,0, "execData1");
        applyStimulus(1,1,0,1,0,0,0, FETCH,0,0,0, "fetchAddr2");
        applyStimulus(1,1,0,1,0,0,0, FETCH,1,1,0, "fetchData2");
        applyStimulus(1,1,0,1,0,0,0, EXEC, 0,0,0, "execAddr2");
        applyStimulus(1,1,0,1,1,1,0, EXEC, 1,0,0, "execToStore");
        applyStimulus(1,1,0,1,1,1,0, STORE,0,0,0, "storeAddrA");
        applyStimulus(1,1,0,1,1,1,0, STORE,1,0,0, "storeDataA");
        applyStimulus(1,1,0,1,1,1,0, FETCH,0,0,0, "indFetchAddr");
        applyStimulus(1,1,0,1,1,1,0, FETCH,1,1,0, "indFetchData");
        applyStimulus(1,1,0,1,1,1,0, DEFER,0,0,0, "deferAddr");
        applyStimulus(1,1,0,1,1,1,0, DEFER,1,0,0, "deferData");
        applyStimulus(1,1,0,1,1,1,0, EXEC, 0,0,0, "indExecAddr");
        applyStimulus(1,1,0,1,1,1,0, EXEC, 1,0,0, "indExecData");
        applyStimulus(1,1,0,1,1,1,0, STORE,0,0,0, "storeAddrB");
        applyStimulus(1,1,0,1,1,1,0, STORE,1,0,0, "storeDataB");
        applyStimulus(1,1,0,1,0,0,0, FETCH,0,0,0, "afterStore");

        for (int i = 0; i < 3; i++)
            applyStimulus(1,1,0,0,0,0,0, FETCH,1,0,0, "waitState");
        applyStimulus(1,1,0,1,0,0,0, FETCH,1,1,0, "waitDone");
        applyStimulus(1,1,0,1,0,0,0, EXEC, 0,0,0, "waitExecAddr");
        applyStimulus(1,1,0,1,0,0,0, EXEC, 1,0,0, "waitExecData");
        applyStimulus(1,1,0,1,0,0,0, FETCH,0,0,0, "preTimeout");

        for (int i = 0; i < 7; i++)
            applyStimulus(1,1,0,0,0,0,0, FETCH,1,0,0, "timeoutWait");
        applyStimulus(1,1,0,1,0,0,0, HALT, 0,0,1, "timeoutHalt");
        applyStimulus(1,1,0,1,0,0,0, HALT, 0,0,1, "faultIgnoresRunA");
        applyStimulus(1,1,0,1,0,0,0, HALT, 0,0,1, "faultIgnoresRunB");
        applyStimulus(0,1,0,1,0,0,0, HALT, 0,0,1, "faultResetEdge");
        applyStimulus(1,1,0,1,0,0,0, HALT, 0,0,0, "faultCleared");

        applyStimulus(1,1,0,1,0,0,0, FETCH,0,0,0, "hltFetchAddr");
        applyStimulus(1,1,0,1,0,0,0, FETCH,1,1,0, "hltFetchData");
        applyStimulus(1,1,0,1,0,0,0, EXEC, 0,0,0, "hltExecAddr");
        applyStimulus(1,1,0,1,0,0,1, EXEC, 1,0,0, "hltExecData");
        applyStimulus(1,1,0,1,0,0,0, HALT, 0,0,0, "haltedByInsn");
        applyStimulus(1,1,0,1,1,0,0, FETCH,0,0,0, "restartFetch");
        applyStimulus(1,1,0,1,1,0,0, FETCH,1,1,0, "restartFetchData");
        applyStimulus(1,1,0,1,0,0,0, DEFER,0,0,0, "midDeferAddr");
        applyStimulus(0,1,0,1,0,0,0, DEFER,1,0,0, "midDeferReset");
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "afterMidReset");

        applyStimulus(1,1,0,1,0,0,0, HALT, 0,0,0, "runDropStart");
        applyStimulus(1,0,0,1,0,0,0, FETCH,0,0,0, "runDropFetchAddr");
        applyStimulus(1,0,0,1,0,0,0, FETCH,1,1,0, "runDropFetchData");
        applyStimulus(1,0,0,1,0,0,0, EXEC, 0,0,0, "runDropExecAddr");
        applyStimulus(1,0,0,1,0,0,0, EXEC, 1,0,0, "runDropExecData");
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "runDropHaltA");
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "runDropHaltB");

        applyStimulus(1,0,1,1,0,0,0, HALT, 0,0,0, "stepPulse");
`ifdef Q2_CYCLE_SEQ_STEP_EN
        applyStimulus(1,0,0,1,0,0,0, FETCH,0,0,0, "stepFetchAddr");
        applyStimulus(1,0,0,1,0,0,0, FETCH,1,1,0, "stepFetchData");
        applyStimulus(1,0,0,1,0,0,0, EXEC, 0,0,0, "stepExecAddr");
        applyStimulus(1,0,0,1,0,0,0, EXEC, 1,0,0, "stepExecData");
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "stepDoneA");
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "stepDoneB");
`else
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "stepIgnoredA");
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "stepIgnoredB");
        applyStimulus(1,0,0,1,0,0,0, HALT, 0,0,0, "stepIgnoredC");
`endif

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drainQueue actual=%0d pending required=0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
